// File: rtl/matrix_pkg.sv
// Shared matrix/memory types for the engine and its memory responder.
// Word layout, transfer direction encoding and handshake FSM states.
package matrix_pkg;

  localparam int MAT_W = 256;
  localparam int ELEM_W = 16;

  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mat_ram_1rw.sv
// Single-port matrix store: synchronous write, registered read.
// Read data reflects the addressed word as of the previous edge.
module mat_ram_1rw #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 256,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mat_mem_responder.sv
// Responder side of the engine EN/RW/Fleg memory handshake.
// Latches a request, waits LATENCY edges, then completes the access.
module mat_mem_responder
  import matrix_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = MAT_W,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              memEN,
  input  logic              memRW,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] toMemBus,
  output logic [DATA_W-1:0] fromMemBus,
  output logic              memFleg,
  output logic              memErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_t state, stateNext;
  logic [3:0] cnt, cntNext;
  logic flegNext, errNext;
  logic accept, done;

  logic              latRw;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;

  logic              inRange;
  logic              ramWe;
  logic [AW-1:0]     ramAddr;
  logic [DATA_W-1:0] ramRdata;
  logic [DATA_W-1:0] busNext;

  assign inRange = {1'b0, latAddr} < DEPTH_V;

  // Read is issued from the live address while idle so that the
  // registered RAM output already holds the word at completion,
  // even when LATENCY is 1.
  assign ramAddr = (state == IDLE) ? memAddr[AW-1:0]
                                   : latAddr[AW-1:0];

  assign ramWe = done && inRange && (latRw == RW_WRITE) && !RESET;

  assign busNext = !inRange             ? '0       :
                   (latRw == RW_READ)   ? ramRdata :
                                          latData;

  mat_ram_1rw #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(latData),
    .rdata(ramRdata)
  );

  // handshake next-state, counter and flag decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    flegNext  = memFleg;
    errNext   = memErr;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (memEN) begin
          accept    = 1'b1;
          cntNext   = CNT_INIT;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (!memEN) begin
          stateNext = IDLE;
        end else if (cnt == 4'd0) begin
          done      = 1'b1;
          flegNext  = 1'b1;
          errNext   = !inRange;
          stateNext = DONE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      DONE: begin
        if (!memEN) begin
          flegNext  = 1'b0;
          errNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // state, counter and response registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      memFleg    <= 1'b0;
      memErr     <= 1'b0;
      fromMemBus <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      memFleg <= flegNext;
      memErr  <= errNext;
      if (done) begin
        fromMemBus <= busNext;
      end
    end
  end

  // request capture; later input changes are ignored until idle
  always_ff @(posedge clk) begin
    if (accept) begin
      latRw   <= memRW;
      latAddr <= memAddr;
      latData <= toMemBus;
    end
  end

endmodule
